// File: rtl/ifu_fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues one fetch at a time and hands instructions to decode.
// Optional incrementer cross-check is built only when IFU_INC_CHECK_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------
// ST_REQ  | may issue a fetch (when no instruction is held)
// ST_WAIT | one fetch outstanding, waiting for the response
module ifu_fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'hAA00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] pc_out,
  input  logic [15:0] pc_inc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [15:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst_data,
  output logic [15:0] inst_pc,
  output logic        inc_err
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [15:0] inst_data_q, inst_data_d;
  logic [15:0] inst_pc_q, inst_pc_d;
  logic        fire;

  // Request depends on registers only, so it never combinationally follows ready.
  assign imem_req_valid = (state_q == ST_REQ) && !inst_valid_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign pc_out        = pc_q;
  assign imem_req_addr = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst_data     = inst_data_q;
  assign inst_pc       = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;

    if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_REQ: begin
        if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_inc;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else if (!redirect_valid) begin
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
          end
        end
      end
    endcase

    // Redirect wins: a response landing this cycle is discarded, otherwise one drop stays pending.
    if (redirect_valid) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      if (state_q == ST_WAIT) begin
        drop_d = !imem_rsp_valid;
      end else if (fire) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      drop_q       <= 1'b0;
      pc_q         <= RESET_PC;
      req_pc_q     <= 16'h0000;
      inst_valid_q <= 1'b0;
      inst_data_q  <= 16'h0000;
      inst_pc_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      drop_q       <= drop_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

`ifdef IFU_INC_CHECK_EN
  logic        inc_err_q, inc_err_d;
  logic [15:0] pc_plus1;

  assign pc_plus1 = pc_q + 16'd1;

  // Sticky until reset; pc_inc is still used as the next PC regardless.
  always_comb begin
    inc_err_d = inc_err_q;
    if (fire && (pc_inc != pc_plus1)) begin
      inc_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_err_q <= 1'b0;
    end else begin
      inc_err_q <= inc_err_d;
    end
  end

  assign inc_err = inc_err_q;
`else
  assign inc_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch_seq.sv
// Bench for ifu_fetch_seq: directed scenarios then random traffic, checked every cycle
// against a queue-based model of outstanding fetches and delivered instructions.
module tb_ifu_fetch_seq;

  localparam logic [15:0] RST_PC = 16'hAA00;
`ifdef IFU_INC_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_out, pc_inc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [15:0] inst_data, inst_pc;
  logic        inc_err;
  logic [15:0] inc_bias;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External incrementer, optionally corrupted
  assign pc_inc = pc_out + inc_bias;

  ifu_fetch_seq #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_inc(pc_inc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .inc_err(inc_err)
  );

  // Values seen by the DUT at the active edge
  logic        smp_fire = 1'b0, smp_acc = 1'b0;
  logic [15:0] smp_addr, smp_pc_inc, smp_idata, smp_ipc;
  always @(posedge clk) begin
    smp_fire   <= rst_n && imem_req_valid && imem_req_ready;
    smp_addr   <= imem_req_addr;
    smp_pc_inc <= pc_inc;
    smp_acc    <= rst_n && inst_valid && inst_ready;
    smp_idata  <= inst_data;
    smp_ipc    <= inst_pc;
  end

  // Behavioural model: fetches in flight, each either still wanted or discarded
  typedef struct packed {logic [15:0] pc; logic wanted;} fetch_t;
  fetch_t      m_inf[$];
  logic [15:0] m_pc, m_idata, m_ipc;
  logic        m_iv, m_err;
  logic [31:0] m_acc[$];
  logic [31:0] dut_acc[$];

  // Memory environment
  typedef struct packed {logic [15:0] addr; logic [3:0] dly;} memreq_t;
  memreq_t memq[$];
  logic    mem_auto, rand_dly, spur_en;
  logic [3:0] fixed_dly;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out actual=waiting expected=event", nm);
  endtask

  task automatic model_reset();
    m_inf.delete();
    m_pc    = RST_PC;
    m_iv    = 1'b0;
    m_idata = 16'h0000;
    m_ipc   = 16'h0000;
    m_err   = 1'b0;
  endtask

  function automatic logic m_req_valid();
    return (m_inf.size() == 0) && !m_iv;
  endfunction

  task automatic model_step();
    logic   fire;
    fetch_t f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = m_req_valid() && imem_req_ready;
    if (m_iv && inst_ready) begin
      m_acc.push_back({m_ipc, m_idata});
      m_iv = 1'b0;
    end
    if (m_inf.size() > 0 && imem_rsp_valid) begin
      f = m_inf.pop_front();
      if (f.wanted && !redirect_valid) begin
        m_iv    = 1'b1;
        m_idata = imem_rsp_data;
        m_ipc   = f.pc;
      end
    end
`ifdef IFU_INC_CHECK_EN
    if (fire && (smp_pc_inc != m_pc + 16'd1)) m_err = 1'b1;
`endif
    if (fire) begin
      m_inf.push_back('{pc: m_pc, wanted: 1'b1});
      m_pc = smp_pc_inc;
    end
    if (redirect_valid) begin
      foreach (m_inf[i]) m_inf[i].wanted = 1'b0;
      m_iv = 1'b0;
      m_pc = redirect_pc;
    end
  endtask

  task automatic compare();
    chk("pc_out", pc_out, m_pc);
    chk("req_addr", imem_req_addr, m_pc);
    chk1("req_valid", imem_req_valid, m_req_valid());
    chk1("inst_valid", inst_valid, m_iv);
    chk("inst_data", inst_data, m_idata);
    chk("inst_pc", inst_pc, m_ipc);
    chk1("inc_err", inc_err, m_err);
  endtask

  task automatic mem_drive();
    if (!mem_auto) return;
    if (memq.size() > 0) begin
      if (memq[0].dly == 4'd0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~memq[0].addr;
        void'(memq.pop_front());
      end else begin
        memq[0].dly    = memq[0].dly - 4'd1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'($urandom);
      end
    end else begin
      imem_rsp_valid = spur_en && ($urandom_range(0, 7) == 0);
      imem_rsp_data  = 16'($urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    if (!rst_n) memq.delete();
    if (smp_fire)
      memq.push_back('{addr: smp_addr,
                       dly: rand_dly ? 4'($urandom_range(0, 3)) : fixed_dly});
    if (smp_acc) dut_acc.push_back({smp_ipc, smp_idata});
    compare();
    mem_drive();
  endtask

  task automatic chk_acc(string nm, int idx, logic [15:0] pc, logic [15:0] data);
    checks++;
    if (dut_acc.size() <= idx || m_acc.size() <= idx) begin
      failures++;
      $display("FAIL %s missing actual=%0d/%0d expected>%0d", nm, dut_acc.size(), m_acc.size(), idx);
    end else begin
      chk({nm, "_dut_pc"}, dut_acc[idx][31:16], pc);
      chk({nm, "_dut_data"}, dut_acc[idx][15:0], data);
      chk({nm, "_model_pc"}, m_acc[idx][31:16], pc);
      chk({nm, "_model_data"}, m_acc[idx][15:0], data);
    end
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (!m_req_valid() && n < 40) begin cycle(); n++; end
    if (!m_req_valid()) timeout(nm);
  endtask

  task automatic wait_inflight(string nm);
    int n = 0;
    while (m_inf.size() == 0 && n < 40) begin cycle(); n++; end
    if (m_inf.size() == 0) timeout(nm);
  endtask

  task automatic wait_acc(string nm, int cnt);
    int n = 0;
    while ((dut_acc.size() < cnt || m_acc.size() < cnt) && n < 60) begin cycle(); n++; end
    if (dut_acc.size() < cnt || m_acc.size() < cnt) timeout(nm);
  endtask

  initial begin
    int b;
    int n;
    rst_n = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_rsp_valid = 1'b0; imem_rsp_data = 16'h0000; inc_bias = 16'd1;
    mem_auto = 1'b1; rand_dly = 1'b0; fixed_dly = 4'd0; spur_en = 1'b0;
    model_reset();
    repeat (3) cycle();
    chk("rst_pc", pc_out, 16'hAA00);
    chk1("rst_req_valid", imem_req_valid, 1'b1);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_data", inst_data, 16'h0000);
    chk("rst_inst_pc", inst_pc, 16'h0000);
    chk1("rst_inc_err", inc_err, 1'b0);

    // Back-to-back fetches, response one cycle after fire, data = ~addr
    rst_n = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    wait_acc("seq3", 3);
    chk_acc("seq0", 0, 16'hAA00, 16'h55FF);
    chk_acc("seq1", 1, 16'hAA01, 16'h55FE);
    chk_acc("seq2", 2, 16'hAA02, 16'h55FD);

    // Decode stall holds the instruction and blocks new requests
    inst_ready = 1'b0;
    n = 0;
    while (!m_iv && n < 20) begin cycle(); n++; end
    if (!m_iv) timeout("stall_wait");
    repeat (5) begin
      cycle();
      chk1("stall_req_valid", imem_req_valid, 1'b0);
      chk1("stall_inst_valid", inst_valid, 1'b1);
    end
    inst_ready = 1'b1;
    cycle();
    chk1("resume_req_valid", imem_req_valid, 1'b1);

    // Redirect while a fetch is outstanding
    fixed_dly = 4'd2;
    wait_inflight("redir_wait");
    b = dut_acc.size();
    redirect_valid = 1'b1; redirect_pc = 16'h1234;
    cycle();
    redirect_valid = 1'b0;
    wait_acc("redir_acc", b + 1);
    chk_acc("redir", b, 16'h1234, 16'hEDCB);

    // Redirect to FFFF in REQ without fire, then wrap
    fixed_dly = 4'd0; imem_req_ready = 1'b0;
    wait_idle("wrap_idle");
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    cycle();
    redirect_valid = 1'b0;
    chk("wrap_pc", pc_out, 16'hFFFF);
    chk1("wrap_req_valid", imem_req_valid, 1'b1);
    b = dut_acc.size();
    imem_req_ready = 1'b1;
    wait_acc("wrap_acc", b + 2);
    chk_acc("wrap0", b, 16'hFFFF, 16'h0000);
    chk_acc("wrap1", b + 1, 16'h0000, 16'hFFFF);

    // Corrupted incrementer on one fire
    imem_req_ready = 1'b0;
    wait_idle("inc_idle");
    inc_bias = 16'd2; imem_req_ready = 1'b1;
    cycle();
    inc_bias = 16'd1; imem_req_ready = 1'b0;
    chk1("inc_err_set", inc_err, EXP_ERR);
    repeat (4) cycle();
    chk1("inc_err_held", inc_err, EXP_ERR);

    // Reset mid-WAIT with a late response after release
    mem_auto = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    wait_idle("rstw_idle");
    wait_inflight("rstw_wait");
    rst_n = 1'b0; imem_req_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 16'hBEEF;
    cycle();
    imem_rsp_valid = 1'b0;
    chk1("rstw_inst_valid", inst_valid, 1'b0);
    chk("rstw_addr", imem_req_addr, 16'hAA00);
    chk1("rstw_req_valid", imem_req_valid, 1'b1);
    chk1("rstw_inc_err", inc_err, 1'b0);
    cycle();
    chk1("rstw_inst_valid2", inst_valid, 1'b0);
    mem_auto = 1'b1;

    // Random traffic
    rand_dly = 1'b1; spur_en = 1'b1;
    repeat (3000) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      inc_bias       = ($urandom_range(0, 299) == 0) ? 16'd2 : 16'd1;
      cycle();
    end
    redirect_valid = 1'b0; inc_bias = 16'd1; inst_ready = 1'b1;
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
